// File: rtl/cp0_exc_arbiter_pkg.sv
// Shared constants for the CP0 exception arbiter: FSM state encoding,
// cause codes, default handler vectors and the BD-slot PC helper.
package cp0_exc_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAVE   = 2'd1,
        ST_REDIR  = 2'd2,
        ST_UNWIND = 2'd3
    } exc_state_e;

    localparam logic [4:0] CAUSE_INT  = 5'd0;
    localparam logic [4:0] CAUSE_ADEL = 5'd4;
    localparam logic [4:0] CAUSE_ADES = 5'd5;
    localparam logic [4:0] CAUSE_SYS  = 5'd8;
    localparam logic [4:0] CAUSE_BP   = 5'd9;
    localparam logic [4:0] CAUSE_RI   = 5'd10;
    localparam logic [4:0] CAUSE_OV   = 5'd12;

    localparam logic [31:0] VEC_EXC_DEF   = 32'hBFC0_0380;
    localparam logic [31:0] VEC_NEST_DEF  = 32'hBFC0_0400;
    localparam logic [31:0] VEC_FATAL_DEF = 32'hBFC0_0480;

    // A faulting delay-slot instruction is restarted from its branch.
    function automatic logic [31:0] save_pc(input logic [31:0] pc, input logic bd);
        return bd ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/cp0_prio_enc.sv
// Fixed-priority encoder: bit 0 of req_i has the highest priority.
// Produces a one-hot grant and the binary index of the winner.
module cp0_prio_enc #(
    parameter int N     = 9,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic found;

    // Scan from index 0 upward; the first set request wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i] && !found) begin
                grant_o[i] = 1'b1;
                idx_o      = IDX_W'(i);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_arbiter.sv
// CP0 exception arbiter/sequencer. Picks the winning exception, drives the
// EPC / nested-EPC hardware write strobes, tracks nesting depth and
// redirects fetch; ERET unwinds one level using the saved EPC.
// Optional statistics counter: define CP0_EXC_STATS_EN to build exc_count.
//
// Handshake: there is no back-pressure. Requests (exc_req, int_req, eret)
// are sampled only while busy is low; once accepted, every sequence runs
// to completion in fixed cycles and requests seen while busy are dropped.
module cp0_exc_arbiter
    import cp0_exc_arbiter_pkg::*;
#(
    parameter int          NUM_SRC   = 8,
    parameter int          MAX_NEST  = 2,
    parameter logic [31:0] VEC_EXC   = VEC_EXC_DEF,
    parameter logic [31:0] VEC_NEST  = VEC_NEST_DEF,
    parameter logic [31:0] VEC_FATAL = VEC_FATAL_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SRC-1:0]     exc_req,
    input  logic [5*NUM_SRC-1:0]   exc_code_in,
    input  logic                   int_req,
    input  logic [31:0]            pc_m,
    input  logic                   bd_m,
    input  logic                   eret,
    input  logic [31:0]            epc_rd,
    input  logic [31:0]            nepc_rd,
    output logic                   epc_we_h,
    output logic                   nepc_we_h,
    output logic [31:0]            pc_save,
    output logic                   bd_save,
    output logic [4:0]             exc_code,
    output logic                   flush,
    output logic                   redirect,
    output logic [31:0]            redirect_pc,
    output logic [1:0]             nest_lvl,
    output logic                   nest_ovf,
    output logic                   busy,
    output logic [15:0]            exc_count,
    output exc_state_e             dbg_state
);

    localparam int          IDX_W   = $clog2(NUM_SRC + 1);
    localparam logic [1:0]  LVL_MAX = 2'(MAX_NEST);

    exc_state_e  state_q, state_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] pcs_q, pcs_d;
    logic        bds_q, bds_d;
    logic [1:0]  lvl_q, lvl_d;
    logic        ovf_q, ovf_d;

    logic [NUM_SRC:0] req_vec;
    logic [NUM_SRC:0] grant;
    logic [IDX_W-1:0] win_idx;
    logic [4:0]       win_code;

    // Interrupt sits above the synchronous sources, so it loses to all of them.
    assign req_vec = {int_req, exc_req};

    cp0_prio_enc #(
        .N     (NUM_SRC + 1),
        .IDX_W (IDX_W)
    ) u_prio (
        .req_i   (req_vec),
        .grant_o (grant),
        .idx_o   (win_idx)
    );

    // Cause code of the winner; the interrupt slot maps to CAUSE_INT.
    always_comb begin
        win_code = CAUSE_INT;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_code = exc_code_in[5*i +: 5];
            end
        end
    end

    // Next-state and output decode for the sequencer.
    always_comb begin
        state_d     = state_q;
        code_d      = code_q;
        pcs_d       = pcs_q;
        bds_d       = bds_q;
        lvl_d       = lvl_q;
        ovf_d       = ovf_q;
        epc_we_h    = 1'b0;
        nepc_we_h   = 1'b0;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (|grant) begin
                    state_d = ST_SAVE;
                    code_d  = win_code;
                    pcs_d   = save_pc(pc_m, bd_m);
                    bds_d   = bd_m;
                end else if (eret) begin
                    state_d = ST_UNWIND;
                end
            end
            ST_SAVE: begin
                flush = 1'b1;
                if (lvl_q == 2'd0) begin
                    epc_we_h = 1'b1;
                end else if (lvl_q == 2'd1 && MAX_NEST == 2) begin
                    nepc_we_h = 1'b1;
                end
                if (lvl_q == LVL_MAX) begin
                    ovf_d = 1'b1;
                end
                state_d = ST_REDIR;
            end
            ST_REDIR: begin
                flush    = 1'b1;
                redirect = 1'b1;
                // Level has not moved yet, so lvl_q is the level before entry.
                if (lvl_q == 2'd0) begin
                    redirect_pc = VEC_EXC;
                end else if (lvl_q == LVL_MAX) begin
                    redirect_pc = VEC_FATAL;
                end else begin
                    redirect_pc = VEC_NEST;
                end
                if (lvl_q != LVL_MAX) begin
                    lvl_d = lvl_q + 2'd1;
                end
                state_d = ST_IDLE;
            end
            ST_UNWIND: begin
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = (lvl_q == 2'd2) ? nepc_rd : epc_rd;
                if (lvl_q != 2'd0) begin
                    lvl_d = lvl_q - 2'd1;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched exception context, nesting level and overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            code_q  <= 5'd0;
            pcs_q   <= 32'h0;
            bds_q   <= 1'b0;
            lvl_q   <= 2'd0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            pcs_q   <= pcs_d;
            bds_q   <= bds_d;
            lvl_q   <= lvl_d;
            ovf_q   <= ovf_d;
        end
    end

    assign pc_save   = pcs_q;
    assign bd_save   = bds_q;
    assign exc_code  = code_q;
    assign nest_lvl  = lvl_q;
    assign nest_ovf  = ovf_q;
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

`ifdef CP0_EXC_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    // SAVE lasts exactly one cycle, so each SAVE cycle is one taken exception.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_SAVE && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Saturating taken-exception counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 16'h0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign exc_count = cnt_q;
`else
    assign exc_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cp0_exc_arbiter.sv
// Directed bench for cp0_exc_arbiter: exception entry, priority, BD-slot
// PC adjust, nesting/overflow, ERET unwind and asynchronous reset abort.
module tb_cp0_exc_arbiter;
    import cp0_exc_arbiter_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  exc_req     = '0;
    logic [39:0] exc_code_in = {5'd13, 5'd12, 5'd10, 5'd9, 5'd8, 5'd12, 5'd5, 5'd4};
    logic        int_req     = 1'b0;
    logic [31:0] pc_m        = '0;
    logic        bd_m        = 1'b0;
    logic        eret        = 1'b0;
    logic [31:0] epc_rd      = '0;
    logic [31:0] nepc_rd     = '0;
    logic        epc_we_h, nepc_we_h, bd_save, flush, redirect, nest_ovf, busy;
    logic [31:0] pc_save, redirect_pc;
    logic [4:0]  exc_code;
    logic [1:0]  nest_lvl;
    logic [15:0] exc_count;
    exc_state_e  dbg_state;

    cp0_exc_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .exc_req     (exc_req),
        .exc_code_in (exc_code_in),
        .int_req     (int_req),
        .pc_m        (pc_m),
        .bd_m        (bd_m),
        .eret        (eret),
        .epc_rd      (epc_rd),
        .nepc_rd     (nepc_rd),
        .epc_we_h    (epc_we_h),
        .nepc_we_h   (nepc_we_h),
        .pc_save     (pc_save),
        .bd_save     (bd_save),
        .exc_code    (exc_code),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .nest_lvl    (nest_lvl),
        .nest_ovf    (nest_ovf),
        .busy        (busy),
        .exc_count   (exc_count),
        .dbg_state   (dbg_state)
    );

`ifdef CP0_EXC_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_bad   = 0;
    int exp_cnt = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_count();
        return STATS_EN ? 32'(exp_cnt) : 32'h0;
    endfunction

    // Every redirect pulse must match the next queued target.
    initial begin
        forever begin
            @(negedge clk);
            if (redirect === 1'b1) begin
                if (exp_q.size() == 0) check("redir_unexpected", 32'd1, 32'd0);
                else                   check("redir_pc", redirect_pc, exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_exc(input logic [7:0] req, input logic irq, input logic er,
                          input logic [31:0] pc, input logic bd,
                          input logic [4:0] e_code, input logic [31:0] e_pcs, input logic e_bds,
                          input logic e_epc, input logic e_nepc, input logic [31:0] e_vec,
                          input logic [1:0] e_lvl, input logic e_ovf);
        @(negedge clk);
        check("idle_before", busy, 1'b0);
        exc_req = req; int_req = irq; eret = er; pc_m = pc; bd_m = bd;
        exp_q.push_back(e_vec);
        exp_cnt++;
        // SAVE: requests here must be ignored; pc_m changes to prove latching.
        @(negedge clk);
        exc_req = 8'hFF; int_req = 1'b1; pc_m = 32'hDEAD_BEEF; bd_m = ~bd;
        check("save_state", dbg_state, ST_SAVE);
        check("save_epc_we", epc_we_h, e_epc);
        check("save_nepc_we", nepc_we_h, e_nepc);
        check("save_pc", pc_save, e_pcs);
        check("save_bd", bd_save, e_bds);
        check("save_code", exc_code, e_code);
        check("save_flush", flush, 1'b1);
        check("save_no_redir", redirect, 1'b0);
        @(negedge clk);
        exc_req = '0; int_req = 1'b0; eret = 1'b0;
        check("redir_state", dbg_state, ST_REDIR);
        check("redir_pulse", redirect, 1'b1);
        check("redir_flush", flush, 1'b1);
        check("redir_no_we", {30'd0, epc_we_h, nepc_we_h}, 32'd0);
        check("redir_ovf", nest_ovf, e_ovf);
        @(negedge clk);
        check("post_busy", busy, 1'b0);
        check("post_redir", redirect, 1'b0);
        check("post_lvl", nest_lvl, e_lvl);
        check("post_count", exc_count, exp_count());
    endtask

    task automatic do_eret(input logic [31:0] epc, input logic [31:0] nepc,
                           input logic [31:0] e_pc, input logic [1:0] e_lvl);
        @(negedge clk);
        check("eret_idle", busy, 1'b0);
        eret = 1'b1; epc_rd = epc; nepc_rd = nepc;
        exp_q.push_back(e_pc);
        @(negedge clk);
        eret = 1'b0;
        check("unw_state", dbg_state, ST_UNWIND);
        check("unw_redir", redirect, 1'b1);
        check("unw_flush", flush, 1'b1);
        check("unw_no_we", {30'd0, epc_we_h, nepc_we_h}, 32'd0);
        @(negedge clk);
        check("unw_busy", busy, 1'b0);
        check("unw_lvl", nest_lvl, e_lvl);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_epc_we"}, epc_we_h, 1'b0);
        check({tag, "_nepc_we"}, nepc_we_h, 1'b0);
        check({tag, "_pc_save"}, pc_save, 32'h0);
        check({tag, "_bd_save"}, bd_save, 1'b0);
        check({tag, "_code"}, exc_code, 5'd0);
        check({tag, "_flush"}, flush, 1'b0);
        check({tag, "_redir"}, redirect, 1'b0);
        check({tag, "_redir_pc"}, redirect_pc, 32'h0);
        check({tag, "_lvl"}, nest_lvl, 2'd0);
        check({tag, "_ovf"}, nest_ovf, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_count"}, exc_count, 16'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        repeat (2) @(negedge clk);
        check_all_zero("rst");
        rst = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("por");
        rst = 1'b1;

        // Single exception from source 2 (OV) at level 0.
        do_exc(8'b0000_0100, 1'b0, 1'b0, 32'h8000_0010, 1'b0,
               5'd12, 32'h8000_0010, 1'b0, 1'b1, 1'b0, 32'hBFC0_0380, 2'd1, 1'b0);
        do_eret(32'h8000_0010, 32'h0, 32'h8000_0010, 2'd0);

        // Source 1 beats source 4 and int_req; concurrent eret is dropped.
        do_exc(8'b0001_0010, 1'b1, 1'b1, 32'h8000_0100, 1'b0,
               5'd5, 32'h8000_0100, 1'b0, 1'b1, 1'b0, 32'hBFC0_0380, 2'd1, 1'b0);
        do_eret(32'h8000_0100, 32'h0, 32'h8000_0100, 2'd0);

        // ERET at level 0 goes to epc_rd and stays at level 0.
        do_eret(32'h8000_0200, 32'h1234_5678, 32'h8000_0200, 2'd0);

        do_reset();

        // Delay-slot exception (SYS): saved PC is the branch.
        do_exc(8'b0000_1000, 1'b0, 1'b0, 32'h8000_0024, 1'b1,
               5'd8, 32'h8000_0020, 1'b1, 1'b1, 1'b0, 32'hBFC0_0380, 2'd1, 1'b0);
        // Nested interrupt at level 1.
        do_exc(8'b0000_0000, 1'b1, 1'b0, 32'h8000_0300, 1'b0,
               5'd0, 32'h8000_0300, 1'b0, 1'b0, 1'b1, 32'hBFC0_0400, 2'd2, 1'b0);
        // Third level overflows: no strobe, fatal vector, sticky overflow.
        do_exc(8'b0000_0001, 1'b0, 1'b0, 32'h8000_0400, 1'b0,
               5'd4, 32'h8000_0400, 1'b0, 1'b0, 1'b0, 32'hBFC0_0480, 2'd2, 1'b1);
        check("count_after_nest", exc_count, STATS_EN ? 32'd3 : 32'd0);

        // Unwind both levels.
        do_eret(32'h8000_0020, 32'h8000_1000, 32'h8000_1000, 2'd1);
        do_eret(32'h8000_0020, 32'h8000_1000, 32'h8000_0020, 2'd0);
        check("ovf_sticky", nest_ovf, 1'b1);

        // Reset asserted during SAVE aborts the sequence immediately.
        @(negedge clk);
        exc_req = 8'b0010_0000; pc_m = 32'h8000_0500; bd_m = 1'b0;
        @(negedge clk);
        exc_req = '0;
        check("mid_save_we", epc_we_h, 1'b1);
        #2 rst = 1'b0;
        #1;
        exp_cnt = 0;
        check_all_zero("mid_rst");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_state", dbg_state, ST_IDLE);
        check("mid_rst_lvl", nest_lvl, 2'd0);

        check("redir_left", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
